// File: rtl/wb_sdrc_arbiter.sv
// ============================================================================
// Module   : wb_sdrc_arbiter
// Brief    : Two-master Wishbone round-robin arbiter in front of sdrc_top.
//            The grant is held for as long as the owning master keeps cyc
//            high, so bursts are never split. The slave-side bus is a
//            combinational mux of the granted master.
//            Optional feature macro: WB_ARB_WATCHDOG_EN (stall watchdog that
//            pulses mN_err_o and forces the grant off after TIMEOUT cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sdrc_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 26,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // master 0
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [aw-1:0]     m0_addr_i,
  input  logic [dw-1:0]     m0_dat_i,
  input  logic [dw/8-1:0]   m0_sel_i,
  input  logic [2:0]        m0_cti_i,
  output logic [dw-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  // master 1
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [aw-1:0]     m1_addr_i,
  input  logic [dw-1:0]     m1_dat_i,
  input  logic [dw/8-1:0]   m1_sel_i,
  input  logic [2:0]        m1_cti_i,
  output logic [dw-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  // shared slave port
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [aw-1:0]     s_addr_o,
  output logic [dw-1:0]     s_dat_o,
  output logic [dw/8-1:0]   s_sel_o,
  output logic [2:0]        s_cti_o,
  input  logic [dw-1:0]     s_dat_i,
  input  logic              s_ack_i,
  // grant status
  output logic [1:0]        gnt_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  // The watchdog limit must fit its 8-bit counter and be non-zero.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_sdrc_arbiter: TIMEOUT must be in 1..255");
  end

  logic [1:0] state_q, state_d;
  logic       rr_q, rr_d;
  logic       timeout_w;

  // Next-grant selection: hold while the owner keeps cyc, hand over directly
  // to a waiting master on release, round-robin tie-break from IDLE.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = rr_q ? ST_GNT1 : ST_GNT0;
        else if (m0_cyc_i)        state_d = ST_GNT0;
        else if (m1_cyc_i)        state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_cyc_i || timeout_w) begin
          rr_d    = 1'b1;
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i || timeout_w) begin
          rr_d    = 1'b0;
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state and round-robin pointer; reset wins over any transition.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Slave-side mux of the granted master; everything reads zero when idle.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = 3'b000;
    case (state_q)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
      end
      ST_GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
      end
      default: ;
    endcase
  end

  // Acks are steered to the owner only, and gated by s_cyc_o so an ack that
  // arrives after the owner abandoned its cycle reaches nobody.
  assign m0_ack_o = s_ack_i & state_q[0] & s_cyc_o;
  assign m1_ack_o = s_ack_i & state_q[1] & s_cyc_o;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = state_q;

`ifdef WB_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Count stalled strobes; any ack, grant change or idle restarts the count.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_IDLE || s_ack_i || state_d != state_q)
      wd_cnt_d = 8'd0;
    else if (s_cyc_o && s_stb_o)
      wd_cnt_d = wd_cnt_q + 8'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wd_cnt_q <= 8'd0;
    else          wd_cnt_q <= wd_cnt_d;
  end

  // Reaching the limit forces a release, which clears the counter, so the
  // error is a single-cycle pulse to the owner.
  assign timeout_w = (state_q != ST_IDLE) && (wd_cnt_q == WD_LIMIT);
  assign m0_err_o  = timeout_w & state_q[0];
  assign m1_err_o  = timeout_w & state_q[1];
`else
  assign timeout_w = 1'b0;
  assign m0_err_o  = 1'b0;
  assign m1_err_o  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_sdrc_arbiter.sv
// ============================================================================
// Module   : tb_wb_sdrc_arbiter
// Brief    : Self-checking bench for wb_sdrc_arbiter: per-cycle vector table,
//            an m1 burst with data scoreboard, and the stall watchdog case
//            (behaviour selected by WB_ARB_WATCHDOG_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sdrc_arbiter;

  localparam int DW = 32;
  localparam int AW = 26;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_dati, m0_dato;
  logic [DW/8-1:0] m0_sel;
  logic [2:0]      m0_cti;
  logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_dati, m1_dato;
  logic [DW/8-1:0] m1_sel;
  logic [2:0]      m1_cti;
  logic            s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_dato, s_dati;
  logic [DW/8-1:0] s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      gnt;

  wb_sdrc_arbiter #(.dw(DW), .aw(AW), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_dat_i(m0_dati), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti),
    .m0_dat_o(m0_dato), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_dat_i(m1_dati), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti),
    .m1_dat_o(m1_dato), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_dat_o(s_dato), .s_sel_o(s_sel), .s_cti_o(s_cti),
    .s_dat_i(s_dati), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  typedef struct {
    logic       rst, c0, c1, ack;
    logic [1:0] gnt;
    logic       scyc, a0, a1;
  } vec_t;

  vec_t        tbl[24];
  vec_t        exp_q[$];
  logic [31:0] sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, c0, c1, a, input logic [1:0] g,
                              input logic sc, a0, a1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.c1 = c1; v.ack = a;
    v.gnt = g; v.scyc = sc; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    int   n_err;
    int   err_at;
    logic [1:0] g_exp;

    // rows: rst c0 c1 ack | gnt scyc ack0 ack1 (outputs seen in that cycle)
    tbl[0]  = mk(0,1,0,0, 2'b00,0,0,0); // m0 alone requests from IDLE
    tbl[1]  = mk(0,1,0,0, 2'b01,1,0,0); // granted one cycle later
    tbl[2]  = mk(0,1,0,0, 2'b01,1,0,0);
    tbl[3]  = mk(0,1,0,1, 2'b01,1,1,0); // ack reaches m0 only
    tbl[4]  = mk(0,0,0,0, 2'b01,0,0,0); // m0 releases
    tbl[5]  = mk(0,0,0,0, 2'b00,0,0,0);
    tbl[6]  = mk(1,0,0,0, 2'b00,0,0,0); // reset -> rr back to 0
    tbl[7]  = mk(0,1,1,0, 2'b00,0,0,0); // both request, rr=0
    tbl[8]  = mk(0,1,1,1, 2'b01,1,1,0); // m0 wins, m1 never sees ack
    tbl[9]  = mk(0,0,1,1, 2'b01,0,0,0); // m0 drops with late ack -> masked
    tbl[10] = mk(0,0,1,0, 2'b10,1,0,0); // direct handover, no idle cycle
    tbl[11] = mk(0,1,1,1, 2'b10,1,0,1);
    tbl[12] = mk(0,1,0,0, 2'b10,0,0,0); // m1 releases, m0 waiting
    tbl[13] = mk(0,1,0,0, 2'b01,1,0,0);
    tbl[14] = mk(0,0,0,0, 2'b01,0,0,0); // release -> IDLE, rr=1
    tbl[15] = mk(0,1,1,0, 2'b00,0,0,0); // both request, rr=1
    tbl[16] = mk(0,1,1,1, 2'b10,1,0,1); // m1 wins this time
    tbl[17] = mk(0,1,0,0, 2'b10,0,0,0);
    tbl[18] = mk(0,1,0,0, 2'b01,1,0,0);
    tbl[19] = mk(1,1,0,1, 2'b01,1,1,0); // reset mid-burst
    tbl[20] = mk(0,1,0,0, 2'b00,0,0,0); // idle right after reset
    tbl[21] = mk(0,1,0,0, 2'b01,1,0,0); // m0 re-granted
    tbl[22] = mk(0,0,0,0, 2'b01,0,0,0); // release -> IDLE, rr=1
    tbl[23] = mk(0,0,0,0, 2'b00,0,0,0);

    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b1; m0_addr = 26'h100;
    m0_dati = 32'hA5A5_A5A5; m0_sel = 4'hF; m0_cti = 3'b000;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b0; m1_addr = 26'h200;
    m1_dati = 32'h5A5A_5A5A; m1_sel = 4'h3; m1_cti = 3'b010;
    s_ack = 0; s_dati = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 24; i++) begin
      rst    = tbl[i].rst;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].c0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].c1;
      s_ack  = tbl[i].ack;
      s_dati = 32'hD000_0000 | 32'(i);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_gnt", i),  32'(gnt),    32'(e.gnt));
      chk($sformatf("v%0d_scyc", i), 32'(s_cyc),  32'(e.scyc));
      chk($sformatf("v%0d_sstb", i), 32'(s_stb),  32'(e.scyc));
      chk($sformatf("v%0d_ack0", i), 32'(m0_ack), 32'(e.a0));
      chk($sformatf("v%0d_ack1", i), 32'(m1_ack), 32'(e.a1));
      chk($sformatf("v%0d_addr", i), 32'(s_addr),
          (e.gnt == 2'b01) ? 32'h100 : (e.gnt == 2'b10) ? 32'h200 : 32'h0);
      chk($sformatf("v%0d_we", i),   32'(s_we),   32'(e.gnt == 2'b01));
      chk($sformatf("v%0d_dat0", i), m0_dato,     32'hD000_0000 | 32'(i));
      chk($sformatf("v%0d_err", i),  32'({m1_err, m0_err}), 32'h0);
      next_cycle();
    end
    rst = 1'b0;

    // ---------------- m1 8-beat burst, m0 requesting throughout -------------
    // state IDLE with rr=1, so m1 wins the tie
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 0;
    @(negedge clk);
    chk("burst_pre_gnt", 32'(gnt), 32'h0);
    next_cycle();
    for (int b = 0; b < 8; b++) begin
      s_ack  = 1'b1;
      s_dati = 32'hB000_0000 + 32'(b);
      sb_q.push_back(s_dati);
      @(negedge clk);
      chk($sformatf("burst%0d_gnt", b), 32'(gnt), 32'h2);
      chk($sformatf("burst%0d_cti", b), 32'(s_cti), 32'h2);
      chk($sformatf("burst%0d_ack0", b), 32'(m0_ack), 32'h0);
      if (m1_ack === 1'b1 && sb_q.size() > 0)
        chk($sformatf("burst%0d_data", b), m1_dato, sb_q.pop_front());
      else
        chk($sformatf("burst%0d_ack1", b), 32'(m1_ack), 32'h1);
      next_cycle();
    end
    chk("burst_sb_empty", 32'(sb_q.size()), 32'h0);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    chk("burst_drop_gnt", 32'(gnt), 32'h2);
    chk("burst_drop_scyc", 32'(s_cyc), 32'h0);
    next_cycle();

    // ---------------- m0 read that never gets acked, m1 pending -------------
    m0_we = 1'b0; m1_cyc = 1; m1_stb = 1;
    n_err = 0; err_at = -1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
`ifdef WB_ARB_WATCHDOG_EN
      g_exp = (c <= 16) ? 2'b01 : 2'b10;
      chk($sformatf("wd%0d_err0", c), 32'(m0_err), 32'(c == 16));
`else
      g_exp = 2'b01;
      chk($sformatf("wd%0d_err0", c), 32'(m0_err), 32'h0);
`endif
      chk($sformatf("wd%0d_gnt", c), 32'(gnt), 32'(g_exp));
      chk($sformatf("wd%0d_err1", c), 32'(m1_err), 32'h0);
      if (m0_err === 1'b1) begin
        n_err++;
        err_at = c;
      end
      next_cycle();
    end
`ifdef WB_ARB_WATCHDOG_EN
    chk("wd_pulses", 32'(n_err), 32'h1);
    chk("wd_pulse_cycle", 32'(err_at), 32'd16);
`else
    chk("wd_pulses", 32'(n_err), 32'h0);
`endif

    // ---------------- reset with both masters active ----------------
    rst = 1'b1; s_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_sstb", 32'(s_stb), 32'h0);
    chk("rst_acks", 32'({m1_ack, m0_ack}), 32'h0);
    chk("rst_errs", 32'({m1_err, m0_err}), 32'h0);
    next_cycle();
    rst = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(gnt), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_rr0", 32'(gnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/wb_sdrc_arbiter.md
WB_SDRC_ARBITER -- requirements
Module: wb_sdrc_arbiter

Interface
REQ-001 Parameter dw, default 32: Wishbone data width; sel width is dw/8.
REQ-002 Parameter aw, default 26: Wishbone address width.
REQ-003 Parameter TIMEOUT, default 255: watchdog limit in cycles, 8-bit range 1..255.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 wb_clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 wb_rst_i  in  1  synchronous, active-high reset.
REQ-007 mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  cycle, strobe and write enable from master N, where N is 0 or 1.
REQ-008 mN_addr_i  in  aw;  mN_dat_i  in  dw;  mN_sel_i  in  dw/8;  mN_cti_i  in  3.  Master N request fields.
REQ-009 mN_dat_o  out  dw  read data to master N;  mN_ack_o  out  1  acknowledge;  mN_err_o  out  1  watchdog error.
REQ-010 s_cyc_o, s_stb_o, s_we_o  out  1 each;  s_addr_o  out  aw;  s_dat_o  out  dw;  s_sel_o  out  dw/8;  s_cti_o  out  3.  Shared port toward sdrc_top.
REQ-011 s_dat_i  in  dw;  s_ack_i  in  1.  Slave response.
REQ-012 gnt_o  out  2  one-hot current grant; 2'b00 means idle.

Function
REQ-013 The arbiter SHALL implement a registered FSM with states IDLE, GNT0 and GNT1; gnt_o reflects the state.
REQ-014 IDLE SHALL go to GNTk when only mk_cyc_i is high, and SHALL go to the master named by the rr pointer when both are high.
REQ-015 The rr pointer SHALL be a 1-bit register naming the preferred master; it SHALL be set to the other master on each grant release.
REQ-016 GNTk SHALL hold while mk_cyc_i is high, so that a CTI-incrementing burst is never split.
REQ-017 When mk_cyc_i falls in GNTk, the FSM SHALL go directly to GNTj if mj_cyc_i is high (no idle cycle), else to IDLE.
REQ-018 Grant latency SHALL be one cycle: a request sampled in IDLE at edge E drives s_cyc_o from the cycle after E.
REQ-019 Slave-side outputs SHALL be a combinational mux of the granted master's inputs.
REQ-020 s_cyc_o and s_stb_o SHALL be ANDed with the grant, and all slave outputs SHALL be 0 when idle.
REQ-021 mk_ack_o SHALL equal s_ack_i AND gnt_o[k]; a non-granted master SHALL never see ack.
REQ-022 mN_dat_o SHALL equal s_dat_i for both masters; a master qualifies the data with its own ack.
REQ-023 If the granted master drops cyc with a transfer outstanding, s_cyc_o SHALL fall in the same cycle, and a late s_ack_i SHALL be masked from both masters.
REQ-024 A master whose request is pending SHALL be granted within one release of the other master (starvation-free).

Reset
REQ-025 On wb_rst_i sampled high, state SHALL become IDLE, rr SHALL become 0 and the watchdog counter SHALL become 0.
REQ-026 From the following cycle s_cyc_o, s_stb_o, mN_ack_o, mN_err_o and gnt_o SHALL all be 0.
REQ-027 Reset SHALL override any FSM transition, including a reset asserted mid-burst.

Configuration
REQ-028 With macro WB_ARB_WATCHDOG_EN defined, an 8-bit counter SHALL count cycles with s_cyc_o and s_stb_o high and s_ack_i low.
REQ-029 The watchdog counter SHALL clear on ack, on grant change and in IDLE.
REQ-030 When the counter reaches TIMEOUT, mk_err_o SHALL pulse for one cycle and the FSM SHALL force the grant off (normal next-grant rules, rr toggled).
REQ-031 The forced release of REQ-030 SHALL apply even if mk_cyc_i is still high, and that master SHALL be re-arbitrated as a new request.
REQ-032 Without WB_ARB_WATCHDOG_EN, no counter SHALL be built, mN_err_o SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-033 Only m0 requests: cyc at cycle 0, write addr 0x100, data 0xA5A5A5A5 -> gnt_o=01 and s_cyc_o high at cycle 1; s_ack_i at cycle 3 -> m0_ack_o high at cycle 3 and m1_ack_o low.
REQ-034 Both masters request at cycle 0 after reset -> grant m0 (rr=0); m0 drops cyc at cycle 5 -> gnt_o=10 at cycle 6 with no idle cycle; m1 releases and both request again -> m0 granted.
REQ-035 m1 runs an 8-beat burst with cti=010 while m0 requests throughout -> m1 keeps the grant for all 8 acks; m0 is granted on the cycle after m1 drops cyc.
REQ-036 wb_rst_i is pulsed for 1 cycle during beat 3 of an m0 burst -> next cycle s_cyc_o=0 and gnt_o=00; the arbiter re-grants m0 one cycle after reset deasserts if m0 cyc is still high.
REQ-037 WB_ARB_WATCHDOG_EN defined, TIMEOUT=16, slave never acks an m0 read -> m0_err_o is a single pulse after 16 stalled cycles, gnt_o becomes 00 (or 10 if m1 pending), and m1 is unaffected.
REQ-038 Same stimulus with the macro undefined -> grant held indefinitely and m0_err_o stays 0.
